// File: rtl/rc_dpdm_gen.sv
// rc_dpdm_gen: receive-side D+/D- line symbol decoder.
// Tracks SYNC, bit field and SE0 EOP framing for handshake and data packets.
module rc_dpdm_gen #(
   parameter int SYNC_LEN    = 8,
   parameter int HS_BITS     = 8,
   parameter int DATA_MIN    = 8,
   parameter int DATA_MAX    = 101,
   parameter int EOP_SE0     = 2,
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       bus_in,
   input  logic             enable,
   input  logic             receive_data,
   input  logic             receive_hshake,
   input  logic             abort,
   output logic             s_out,
   output logic             s_valid,
   output logic             start_rc_nrzi,
   output logic             got_sync,
   output logic             end_rc_nrzi,
   output logic             pkt_done,
   output logic             EOP_error,
   output logic             rc_dpdm_wait,
   output logic             timeout,
   output logic [CNT_W-1:0] bit_count
);

   localparam int SW = $clog2(SYNC_LEN);
   localparam int EW = $clog2(EOP_SE0 + 1);
   localparam int IW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [SW-1:0]    SYNC_LAST = SW'(SYNC_LEN - 1);
   localparam logic [EW-1:0]    EOP_N     = EW'(EOP_SE0);
   localparam logic [IW-1:0]    TO_N      = IW'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] HS_N      = CNT_W'(HS_BITS);
   localparam logic [CNT_W-1:0] DMIN_N    = CNT_W'(DATA_MIN);
   localparam logic [CNT_W-1:0] DMAX_N    = CNT_W'(DATA_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_RECV,
      S_EOP,
      S_ERROR
   } state_t;

   state_t           state, state_nxt;
   logic             hs_mode, hs_nxt;
   logic [SW-1:0]    sync_idx, sync_nxt;
   logic [EW-1:0]    se0_cnt, se0_nxt;
   logic [IW-1:0]    idle_cnt, idle_nxt;
   logic [CNT_W-1:0] bc_nxt;

   logic             seen_j, seen_k, seen_x, rx_req;
   logic             exp_k, sync_ok, len_ok;
   logic [CNT_W-1:0] limit;
   logic             start_c, valid_c, sync_c, end_c, done_c, to_c;

   assign seen_j = !enable && (bus_in == 2'b10);
   assign seen_k = !enable && (bus_in == 2'b01);
   assign seen_x = !enable && (bus_in == 2'b00);
   assign rx_req = receive_data || receive_hshake;

   assign exp_k   = (sync_idx == SYNC_LAST) || !sync_idx[0];
   assign sync_ok = exp_k ? seen_k : seen_j;
   assign limit   = hs_mode ? HS_N : DMAX_N;
   assign len_ok  = hs_mode ? (bit_count == HS_N)
                            : (bit_count >= DMIN_N && bit_count <= DMAX_N);

   // Next-state, counter and pulse decode; abort overrides everything.
   always_comb begin
      state_nxt = state;
      hs_nxt    = hs_mode;
      sync_nxt  = sync_idx;
      se0_nxt   = se0_cnt;
      bc_nxt    = bit_count;
      idle_nxt  = '0;
      start_c   = 1'b0;
      valid_c   = 1'b0;
      sync_c    = 1'b0;
      end_c     = 1'b0;
      done_c    = 1'b0;
      to_c      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (seen_k && rx_req) begin
               start_c   = 1'b1;
               state_nxt = S_SYNC;
               sync_nxt  = SW'(1);
               bc_nxt    = '0;
               hs_nxt    = receive_hshake;
            end else if (!rx_req) begin
               idle_nxt = '0;
            end else if (idle_cnt == TO_N) begin
               to_c     = 1'b1;
               idle_nxt = '0;
            end else begin
               idle_nxt = idle_cnt + 1'b1;
            end
         end
         S_SYNC: begin
            if (!sync_ok) begin
               state_nxt = S_IDLE;
               sync_nxt  = '0;
            end else if (sync_idx == SYNC_LAST) begin
               sync_c    = 1'b1;
               state_nxt = S_RECV;
               bc_nxt    = '0;
            end else begin
               sync_nxt = sync_idx + 1'b1;
            end
         end
         S_RECV: begin
            if ((seen_j || seen_k) && bit_count < limit) begin
               valid_c = 1'b1;
               bc_nxt  = bit_count + 1'b1;
            end else begin
               end_c = 1'b1;
               if (seen_x && len_ok) begin
                  state_nxt = S_EOP;
                  se0_nxt   = EW'(1);
               end else begin
                  state_nxt = S_ERROR;
               end
            end
         end
         S_EOP: begin
            if (seen_x && se0_cnt < EOP_N) begin
               se0_nxt = se0_cnt + 1'b1;
            end else if (seen_j && se0_cnt == EOP_N) begin
               done_c    = 1'b1;
               state_nxt = S_IDLE;
               se0_nxt   = '0;
            end else begin
               state_nxt = S_ERROR;
            end
         end
         S_ERROR: begin
            state_nxt = S_ERROR;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         sync_nxt  = '0;
         se0_nxt   = '0;
         bc_nxt    = '0;
         idle_nxt  = '0;
         start_c   = 1'b0;
         valid_c   = 1'b0;
         sync_c    = 1'b0;
         end_c     = 1'b0;
         done_c    = 1'b0;
         to_c      = 1'b0;
      end
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         hs_mode   <= 1'b0;
         sync_idx  <= '0;
         se0_cnt   <= '0;
         idle_cnt  <= '0;
         bit_count <= '0;
      end else begin
         state     <= state_nxt;
         hs_mode   <= hs_nxt;
         sync_idx  <= sync_nxt;
         se0_cnt   <= se0_nxt;
         idle_cnt  <= idle_nxt;
         bit_count <= bc_nxt;
      end
   end

   assign s_valid       = rst_n && valid_c;
   assign s_out         = s_valid && seen_j;
   assign start_rc_nrzi = rst_n && sync_c;
   assign got_sync      = rst_n && sync_c;
   assign end_rc_nrzi   = rst_n && end_c;
   assign pkt_done      = rst_n && done_c;
   assign timeout       = rst_n && to_c;
   assign EOP_error     = rst_n && (state == S_ERROR);
   assign rc_dpdm_wait  = !rst_n || ((state == S_IDLE) && !start_c);

endmodule

// File: tb/tb_rc_dpdm_gen.sv
// tb_rc_dpdm_gen: randomized packet-level bench for rc_dpdm_gen.
// Expected outputs are derived from each packet's construction.
module tb_rc_dpdm_gen;

   localparam int SL   = 8;
   localparam int HB   = 8;
   localparam int DMIN = 8;
   localparam int DMAX = 101;
   localparam int ES   = 2;
   localparam int TO   = 255;
   localparam int CW   = 8;

   localparam logic [1:0] J = 2'b10;
   localparam logic [1:0] K = 2'b01;
   localparam logic [1:0] X = 2'b00;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    bus_in = J;
   logic          enable = 1'b0;
   logic          receive_data = 1'b0;
   logic          receive_hshake = 1'b0;
   logic          abort = 1'b0;
   logic          s_out, s_valid, start_rc_nrzi, got_sync;
   logic          end_rc_nrzi, pkt_done, EOP_error, rc_dpdm_wait, timeout;
   logic [CW-1:0] bit_count;

   logic rst_v = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   rc_dpdm_gen #(
      .SYNC_LEN(SL), .HS_BITS(HB), .DATA_MIN(DMIN), .DATA_MAX(DMAX),
      .EOP_SE0(ES), .TIMEOUT_CYC(TO), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .enable(enable),
      .receive_data(receive_data), .receive_hshake(receive_hshake),
      .abort(abort), .s_out(s_out), .s_valid(s_valid),
      .start_rc_nrzi(start_rc_nrzi), .got_sync(got_sync),
      .end_rc_nrzi(end_rc_nrzi), .pkt_done(pkt_done),
      .EOP_error(EOP_error), .rc_dpdm_wait(rc_dpdm_wait),
      .timeout(timeout), .bit_count(bit_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // order: valid,s_out,got_sync,start,end,done,error,wait,timeout
   function automatic logic [8:0] ex(input bit v, o, sy, e, d, er, w, t);
      return {v, o, sy, sy, e, d, er, w, t};
   endfunction

   function automatic logic [8:0] obs();
      return {s_valid, s_out, got_sync, start_rc_nrzi, end_rc_nrzi,
              pkt_done, EOP_error, rc_dpdm_wait, timeout};
   endfunction

   function automatic logic [1:0] sync_sym(input int i);
      return (i == SL-1 || i % 2 == 0) ? K : J;
   endfunction

   task automatic step(input string tag, input logic [1:0] sym,
                       input logic en, ab, rh, rd, input logic [8:0] e);
      @(negedge clk);
      rst_n = rst_v;
      bus_in = sym;
      enable = en;
      abort = ab;
      receive_hshake = rh;
      receive_data = rd;
      #2;
      chk(tag, 32'(obs()), 32'(e));
   endtask

   task automatic run_pkt(input string tag, input bit hs, input bit both,
                          input int nbits, input int pat, input bit bad_tail,
                          input int none_at, input int cut_at,
                          input bit cut_rst);
      int   lim;
      int   bc;
      bit   err;
      bit   ok;
      bit   r;
      logic rh, rd;
      lim = hs ? HB : DMAX;
      bc  = 0;
      err = 1'b0;
      rh  = hs;
      rd  = !hs || both;
      for (int i = 0; i < SL; i++)
         step({tag, ":sync"}, sync_sym(i), 0, 0, rh, rd,
              ex(0, 0, i == SL-1, 0, 0, 0, 0, 0));
      for (int b = 0; b < nbits; b++) begin
         if (b == cut_at) begin
            if (cut_rst) begin
               rst_v = 1'b0;
               step({tag, ":rst"}, J, 0, 0, rh, rd, ex(0,0,0,0,0,0,1,0));
               rst_v = 1'b1;
            end else begin
               step({tag, ":abort"}, J, 0, 1, rh, rd, ex(0,0,0,0,0,0,0,0));
            end
            step({tag, ":cutidle"}, J, 0, 0, 0, 0, ex(0,0,0,0,0,0,1,0));
            chk({tag, ":cutbc"}, 32'(bit_count), 0);
            return;
         end
         r = (pat < 0) ? 1'($urandom) : pat[nbits-1-b];
         if (b == none_at) begin
            step({tag, ":none"}, J, 1, 0, rh, rd, ex(0,0,0,1,0,0,0,0));
            err = 1'b1;
            break;
         end
         if (b >= lim) begin
            step({tag, ":over"}, r ? J : K, 0, 0, rh, rd,
                 ex(0,0,0,1,0,0,0,0));
            err = 1'b1;
            break;
         end
         step({tag, ":bit"}, r ? J : K, 0, 0, rh, rd,
              ex(1, r, 0, 0, 0, 0, 0, 0));
         bc++;
      end
      if (!err) begin
         ok = hs ? (nbits == HB) : (nbits >= DMIN);
         step({tag, ":x1"}, X, 0, 0, rh, rd, ex(0,0,0,1,0,0,0,0));
         if (!ok) begin
            err = 1'b1;
         end else if (bad_tail) begin
            step({tag, ":xk"}, K, 0, 0, rh, rd, ex(0,0,0,0,0,0,0,0));
            err = 1'b1;
         end else begin
            for (int j = 1; j < ES; j++)
               step({tag, ":xn"}, X, 0, 0, rh, rd, ex(0,0,0,0,0,0,0,0));
            step({tag, ":eopj"}, J, 0, 0, rh, rd, ex(0,0,0,0,1,0,0,0));
         end
      end
      if (err) begin
         step({tag, ":err"}, 2'($urandom), 1'($urandom), 0, rh, rd,
              ex(0,0,0,0,0,1,0,0));
         chk({tag, ":bc"}, 32'(bit_count), 32'(bc));
         step({tag, ":err2"}, 2'($urandom), 1'($urandom), 0, rh, rd,
              ex(0,0,0,0,0,1,0,0));
         step({tag, ":abort"}, J, 0, 1, rh, rd, ex(0,0,0,0,0,1,0,0));
         step({tag, ":idle"}, J, 0, 0, 0, 0, ex(0,0,0,0,0,0,1,0));
      end else begin
         step({tag, ":idle"}, J, 0, 0, 0, 0, ex(0,0,0,0,0,0,1,0));
         chk({tag, ":bc"}, 32'(bit_count), 32'(bc));
      end
   endtask

   task automatic bad_sync(input string tag, input int m, input bit use_none);
      logic [1:0] s;
      for (int i = 0; i < m; i++)
         step({tag, ":ok"}, sync_sym(i), 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0));
      s = (sync_sym(m) == K) ? J : K;
      step({tag, ":bad"}, s, use_none, 0, 0, 1, ex(0,0,0,0,0,0,0,0));
      step({tag, ":idle"}, J, 0, 0, 0, 0, ex(0,0,0,0,0,0,1,0));
   endtask

   initial begin
      int nb;
      int na;
      int nc;
      bit hs;
      rst_v = 1'b0;
      for (int i = 0; i < 3; i++)
         step("reset", 2'($urandom), 1'($urandom), 1'($urandom), 1, 1,
              ex(0,0,0,0,0,0,1,0));
      chk("reset_bc", 32'(bit_count), 0);
      rst_v = 1'b1;
      step("idle0", J, 0, 0, 0, 0, ex(0,0,0,0,0,0,1,0));

      run_pkt("hs", 1, 0, 8, 32'h9D, 0, -1, -1, 0);
      run_pkt("d40", 0, 0, 40, -1, 0, -1, -1, 0);
      run_pkt("d5", 0, 0, 5, -1, 0, -1, -1, 0);
      run_pkt("d102", 0, 0, 102, -1, 0, -1, -1, 0);
      bad_sync("bsync", 4, 0);

      for (int c = 0; c < 600; c++)
         step("to", J, 0, 0, 0, 1,
              ex(0, 0, 0, 0, 0, 0, 1, (c == TO) || (c == 2*TO + 1)));
      step("to_end", J, 0, 0, 0, 0, ex(0,0,0,0,0,0,1,0));

      run_pkt("hsbad", 1, 0, 8, -1, 1, -1, -1, 0);
      run_pkt("both", 1, 1, 8, -1, 0, -1, -1, 0);
      run_pkt("abrt", 0, 0, 30, -1, 0, -1, 12, 0);
      run_pkt("mrst", 1, 0, 8, -1, 0, -1, 3, 1);
      run_pkt("post", 0, 0, DMAX, -1, 0, -1, -1, 0);
      bad_sync("bnone", SL-1, 1);

      for (int k = 0; k < 40; k++) begin
         hs = 1'($urandom);
         if (hs) nb = ($urandom % 3 == 0) ? int'($urandom_range(0, 12)) : HB;
         else    nb = int'($urandom_range(0, 110));
         na = ($urandom % 6 == 0) ? int'($urandom_range(0, nb)) : -1;
         nc = ($urandom % 8 == 0) ? int'($urandom_range(0, nb)) : -1;
         run_pkt("rnd", hs, 1'($urandom), nb, -1, ($urandom % 5 == 0),
                 na, nc, 1'($urandom));
         if ($urandom % 4 == 0)
            bad_sync("rbs", int'($urandom_range(1, SL-1)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rc_dpdm_gen.md
RC_DPDM_GEN -- requirements
Module: rc_dpdm_gen

Interface
REQ-001 Parameter SYNC_LEN, default 8: SYNC symbol count; the pattern is alternating K,J for the first SYNC_LEN-2 symbols, followed by K,K (8 gives KJKJKJKK); legal values are even and >=4.
REQ-002 Parameter HS_BITS, default 8: exact number of bit symbols in a handshake packet.
REQ-003 Parameter DATA_MIN, default 8: minimum number of bit symbols in a data packet.
REQ-004 Parameter DATA_MAX, default 101: maximum number of bit symbols in a data packet.
REQ-005 Parameter EOP_SE0, default 2: consecutive SE0 (X) symbols forming the EOP.
REQ-006 Parameter TIMEOUT_CYC, default 255: idle cycles without a start K before a timeout pulse.
REQ-007 Parameter CNT_W, default 8: width of the bit counter and bit_count; it shall hold DATA_MAX.
REQ-008 clk  in  1  single clock, all state changes on the rising edge.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 bus_in  in  2  line symbol: 2'b10=J, 2'b01=K, 2'b00=X (SE0), 2'b11=invalid.
REQ-011 enable  in  1  local transmitter is driving; while 1, bus_in is ignored.
REQ-012 receive_data  in  1  level; protocol FSM expects a data packet.
REQ-013 receive_hshake  in  1  level; protocol FSM expects a handshake packet.
REQ-014 abort  in  1  synchronous return to IDLE.
REQ-015 s_out  out  1  decoded line bit: J=1, K=0.
REQ-016 s_valid  out  1  s_out is valid this cycle.
REQ-017 start_rc_nrzi  out  1  one-cycle pulse on the final SYNC symbol.
REQ-018 got_sync  out  1  one-cycle pulse, identical timing to start_rc_nrzi.
REQ-019 end_rc_nrzi  out  1  one-cycle pulse on the symbol that ends the bit field.
REQ-020 pkt_done  out  1  one-cycle pulse when a packet with a good EOP completes.
REQ-021 EOP_error  out  1  high while in ERROR.
REQ-022 rc_dpdm_wait  out  1  high in IDLE while no start K is being accepted.
REQ-023 timeout  out  1  one-cycle idle timeout pulse.
REQ-024 bit_count  out  CNT_W  bit symbols received so far in the current packet.

Function
REQ-025 Symbol predicates: seen_J/K/X are true only when enable=0 and bus_in matches; enable=1 or 2'b11 is a "none" symbol.
REQ-026 States: IDLE, SYNC, RECV, EOP, ERROR.
REQ-027 IDLE: when seen_K and (receive_hshake or receive_data), go to SYNC, clear sync_idx to 1 and latch the mode; receive_hshake has priority if both are asserted.
REQ-028 SYNC: for each symbol index i from 1 to SYNC_LEN-1, the expected symbol is J for odd i, K for even i, and K for i=SYNC_LEN-1; a mismatch (including none) returns to IDLE without error.
REQ-029 SYNC final match: start_rc_nrzi=got_sync=1 combinationally in that cycle, then go to RECV with bit_count=0.
REQ-030 RECV, seen_J or seen_K, with bit_count below the mode limit (HS_BITS or DATA_MAX): s_valid=1, s_out=J?1:0, and bit_count increments.
REQ-031 RECV, seen_X: end_rc_nrzi=1 and go to EOP with se0_cnt=1, if (hshake mode and bit_count==HS_BITS) or (data mode and DATA_MIN<=bit_count<=DATA_MAX); otherwise go to ERROR.
REQ-032 RECV, J/K received at the limit, or a none symbol: end_rc_nrzi=1 and go to ERROR.
REQ-033 EOP: on seen_X with se0_cnt<EOP_SE0, increment se0_cnt; on seen_J with se0_cnt==EOP_SE0, pulse pkt_done and go to IDLE; any other symbol goes to ERROR.
REQ-034 ERROR: sticky; EOP_error=1; exited only by abort or rst_n.
REQ-035 Timeout: in IDLE with (receive_data or receive_hshake)=1 and no start K, idle_cnt increments; when it reaches TIMEOUT_CYC, timeout pulses for one cycle and idle_cnt restarts from 0.
REQ-036 Timeout counter clear: idle_cnt clears when IDLE is left or when both receive inputs are 0.
REQ-037 abort: has priority over all transitions; next state is IDLE and all counters clear; in the abort cycle every pulse output and s_valid are forced to 0.
REQ-038 bit_count holds its value through EOP and ERROR, and clears on entry to SYNC.

Reset
REQ-039 With rst_n=0 at a rising edge: state=IDLE; bit_count, sync_idx, se0_cnt and idle_cnt=0.
REQ-040 While in reset: all 1-bit outputs are 0 except rc_dpdm_wait=1.
REQ-041 Reset mid-packet: the next cycle behaves as fresh IDLE, with no pkt_done or error.

Verification
REQ-042 Handshake: receive_hshake=1; bus KJKJKJKK, 8 bits J,K,K,J,J,J,K,J, then X,X,J -> got_sync pulses on the 8th symbol, s_out stream 10011101, end_rc_nrzi pulses on the first X, pkt_done pulses on the J, state returns to IDLE.
REQ-043 Variable-length data: receive_data=1; SYNC, 40 bits, X,X,J -> 40 s_valid pulses, bit_count=40, pkt_done; the same packet with 5 bits -> ERROR with EOP_error=1.
REQ-044 Overrun: data mode with 102 J/K symbols -> 101 valid bits, then ERROR on symbol 102; abort -> IDLE next cycle with EOP_error=0.
REQ-045 Bad SYNC: KJKJJ -> return to IDLE on the 5th symbol, no got_sync, no error; rc_dpdm_wait=1.
REQ-046 Timeout: receive_data=1 with bus idle J for 600 cycles -> timeout pulses at cycles 255 and 511 only.
REQ-047 Bad EOP: handshake followed by X,K -> ERROR.
